// File: rtl/red_pitaya_decimator.sv
`default_nettype none
// ============================================================================
// Module  : red_pitaya_decimator
// Purpose : Decimates a signed sample stream by 1..65536, emitting either the
//           window average (arithmetic shift) or the last sample per window.
// Rev     : 1.0  initial release
// ============================================================================
module red_pitaya_decimator #(
  parameter int DW = 14
) (
  input  logic          adc_clk_i,
  input  logic          adc_rst_i,
  input  logic [DW-1:0] adc_dat_i,
  input  logic          adc_dv_i,
  input  logic [2:0]    cfg_dec_i,
  input  logic          cfg_avg_i,
  input  logic          ctl_rst_i,
  output logic [DW-1:0] dec_dat_o,
  output logic          dec_dv_o
);

  localparam int AW = DW + 16;

  logic [15:0]          r_cnt;
  logic signed [AW-1:0] r_acc;
  logic [2:0]           r_dec;
  logic                 r_avg;
  logic [DW-1:0]        r_dat;
  logic                 r_dv;

  logic [15:0]          w_last;
  logic [4:0]           w_shift;
  logic signed [AW-1:0] w_sum;
  logic signed [AW-1:0] w_avg;
  logic                 w_cfg_chg;

  // Window length is taken from the registered code; 6 and 7 alias code 0.
  always_comb begin
    w_last  = 16'd0;
    w_shift = 5'd0;
    case (r_dec)
      3'd1:    begin w_last = 16'd7;     w_shift = 5'd3;  end
      3'd2:    begin w_last = 16'd63;    w_shift = 5'd6;  end
      3'd3:    begin w_last = 16'd1023;  w_shift = 5'd10; end
      3'd4:    begin w_last = 16'd8191;  w_shift = 5'd13; end
      3'd5:    begin w_last = 16'd65535; w_shift = 5'd16; end
      default: begin w_last = 16'd0;     w_shift = 5'd0;  end
    endcase
  end

  assign w_sum     = r_acc + {{16{adc_dat_i[DW-1]}}, adc_dat_i};
  assign w_avg     = w_sum >>> w_shift;
  assign w_cfg_chg = (cfg_dec_i != r_dec) || (cfg_avg_i != r_avg);

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_dec <= '0;
      r_avg <= 1'b0;
      r_dat <= '0;
      r_dv  <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      // Config change beats ctl restart; both discard the current sample.
      if (w_cfg_chg) begin
        r_dec <= cfg_dec_i;
        r_avg <= cfg_avg_i;
        r_cnt <= '0;
        r_acc <= '0;
      end else if (ctl_rst_i) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else if (adc_dv_i) begin
        if (r_cnt == w_last) begin
          r_cnt <= '0;
          r_acc <= '0;
          r_dv  <= 1'b1;
          r_dat <= r_avg ? w_avg[DW-1:0] : adc_dat_i;
        end else begin
          r_cnt <= r_cnt + 16'd1;
          r_acc <= w_sum;
        end
      end
    end
  end

  assign dec_dat_o = r_dat;
  assign dec_dv_o  = r_dv;

endmodule
`default_nettype wire
